// File: rtl/key_event_decoder_if.sv
// Key level in, classified key events out.
interface key_event_decoder_if;
    logic key_db;
    logic click;
    logic dbl_click;
    logic long_press;
    logic repeat_tick;
    logic key_hold;

    modport master (
        input  key_db,
        output click, dbl_click, long_press, repeat_tick, key_hold
    );

    modport slave (
        output key_db,
        input  click, dbl_click, long_press, repeat_tick, key_hold
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key press sequences into click, double click or
// long press with auto-repeat, each reported as a one-cycle pulse.
module key_event_decoder #(
    parameter int unsigned LONG_CNT = 50,
    parameter int unsigned DBL_GAP  = 20,
    parameter int unsigned REP_CNT  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    key_event_decoder_if.master  kif
);
    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_T  = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(DBL_GAP);
    localparam logic [CNT_W-1:0] REP_T   = CNT_W'(REP_CNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic             key_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rcnt_inc;
    logic             press;
    logic             rel;

    assign press = key_d & ~kif.key_db;
    assign rel   = ~key_d & kif.key_db;

    // Saturating increments; the terminal compare fires before saturation matters
    assign cnt_inc  = (cnt  == CNT_MAX) ? cnt  : cnt  + ONE;
    assign rcnt_inc = (rcnt == CNT_MAX) ? rcnt : rcnt + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            key_d           <= 1'b1;
            cnt             <= '0;
            rcnt            <= '0;
            kif.click       <= 1'b0;
            kif.dbl_click   <= 1'b0;
            kif.long_press  <= 1'b0;
            kif.repeat_tick <= 1'b0;
            kif.key_hold    <= 1'b0;
        end else begin
            key_d           <= kif.key_db;
            kif.click       <= 1'b0;
            kif.dbl_click   <= 1'b0;
            kif.long_press  <= 1'b0;
            kif.repeat_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        cnt   <= ONE;
                        state <= PRESS1;
                    end
                end
                PRESS1: begin
                    if (rel) begin
                        cnt   <= ONE;
                        state <= WAIT2;
                    end else if (cnt_inc == LONG_T) begin
                        kif.long_press <= 1'b1;
                        kif.key_hold   <= 1'b1;
                        rcnt           <= '0;
                        state          <= LONG;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT2: begin
                    if (press) begin
                        state <= PRESS2;
                    end else if (cnt_inc == GAP_T) begin
                        kif.click <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESS2: begin
                    if (rel) begin
                        kif.dbl_click <= 1'b1;
                        state         <= IDLE;
                    end
                end
                LONG: begin
                    // Release wins over a tick due on the same sample
                    if (rel) begin
                        kif.key_hold <= 1'b0;
                        rcnt         <= '0;
                        state        <= IDLE;
                    end else if (rcnt_inc == REP_T) begin
                        kif.repeat_tick <= 1'b1;
                        rcnt            <= '0;
                    end else begin
                        rcnt <= rcnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench: directed segment table plus random key traffic
// against a run-length reference model.
module tb_key_event_decoder;
    localparam int LONG_CNT = 50;
    localparam int DBL_GAP  = 20;
    localparam int REP_CNT  = 10;

    logic clk = 1'b0;
    logic rst;
    key_event_decoder_if kif();

    key_event_decoder #(
        .LONG_CNT(LONG_CNT), .DBL_GAP(DBL_GAP), .REP_CNT(REP_CNT), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phases of a press sequence, driven by run lengths
    int m_phase = 0;
    int m_run   = 0;
    bit m_prev  = 1'b1;
    bit m_hold  = 1'b0;
    bit e_click, e_dbl, e_long, e_rep;

    typedef struct {
        bit r;
        bit k;
        int len;
        int n_click;
        int n_dbl;
        int n_long;
        int n_rep;
        bit hold_end;
        int at;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t mk(input bit r, input bit k, input int len,
                                input int c, input int d, input int l,
                                input int rp, input bit h, input int at);
        seg_t s;
        s.r = r; s.k = k; s.len = len;
        s.n_click = c; s.n_dbl = d; s.n_long = l; s.n_rep = rp;
        s.hold_end = h; s.at = at;
        return s;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, got, exp);
    endtask

    task automatic model(input bit r, input bit s);
        e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (r) begin
            m_phase = 0; m_run = 0; m_prev = 1'b1; m_hold = 1'b0;
        end else begin
            m_run = (s == m_prev) ? m_run + 1 : 1;
            case (m_phase)
                0: if (!s && m_prev) m_phase = 1;
                1: if (s) m_phase = 2;
                   else if (m_run == LONG_CNT) begin
                       e_long = 1'b1; m_hold = 1'b1; m_phase = 4;
                   end
                2: if (!s) m_phase = 3;
                   else if (m_run == DBL_GAP) begin
                       e_click = 1'b1; m_phase = 0;
                   end
                3: if (s) begin e_dbl = 1'b1; m_phase = 0; end
                4: if (s) begin m_hold = 1'b0; m_phase = 0; end
                   else if ((m_run - LONG_CNT) % REP_CNT == 0) e_rep = 1'b1;
                default: m_phase = 0;
            endcase
            m_prev = s;
        end
    endtask

    // One clock: drive, let the DUT sample, then compare mid-cycle
    task automatic step(input bit r, input bit k);
        logic [4:0] got;
        logic [4:0] exp;
        rst = r;
        kif.key_db = k;
        @(posedge clk);
        model(r, k);
        @(negedge clk);
        cyc++;
        got = {kif.click, kif.dbl_click, kif.long_press, kif.repeat_tick, kif.key_hold};
        exp = {e_click, e_dbl, e_long, e_rep, m_hold};
        check("outputs vs model {clk,dbl,long,rep,hold}", int'(got), int'(exp));
    endtask

    task automatic run_seg(input int idx, input seg_t s);
        int c = 0, d = 0, l = 0, rp = 0, first = 0;
        for (int i = 1; i <= s.len; i++) begin
            step(s.r, s.k);
            c  += int'(kif.click);
            d  += int'(kif.dbl_click);
            l  += int'(kif.long_press);
            rp += int'(kif.repeat_tick);
            if (first == 0 && (kif.click || kif.dbl_click || kif.long_press)) first = i;
        end
        check($sformatf("seg%0d click count", idx), c, s.n_click);
        check($sformatf("seg%0d dbl_click count", idx), d, s.n_dbl);
        check($sformatf("seg%0d long_press count", idx), l, s.n_long);
        check($sformatf("seg%0d repeat_tick count", idx), rp, s.n_rep);
        check($sformatf("seg%0d key_hold at end", idx), int'(kif.key_hold), int'(s.hold_end));
        check($sformatf("seg%0d event sample index", idx), first, s.at);
    endtask

    initial begin
        rst = 1'b1;
        kif.key_db = 1'b1;
        //          r  k  len  clk dbl lng rep hold at
        tbl.push_back(mk(1, 1,   3, 0, 0, 0, 0, 0,  0));
        // reset abort mid-hold, then reset with key released
        tbl.push_back(mk(0, 0,  30, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 0,   3, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(1, 1,   2, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,   5, 0, 0, 0, 0, 0,  0));
        // short click
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 1, 0, 0, 0, 0, 20));
        // double click
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,   8, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 0, 1, 0, 0, 0,  1));
        // long press with repeats
        tbl.push_back(mk(0, 0, 100, 0, 0, 1, 5, 1, 50));
        tbl.push_back(mk(0, 1,  25, 0, 0, 0, 0, 0,  0));
        // gap of 19 highs: double click
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  19, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 0, 1, 0, 0, 0,  1));
        // gap of 20 highs: click, then a fresh sequence
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  20, 1, 0, 0, 0, 0, 20));
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 1, 0, 0, 0, 0, 20));
        // long second press still a double click
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,   5, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0,  80, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 0, 1, 0, 0, 0,  1));
        // reset during long hold with key still low: new press after reset
        tbl.push_back(mk(0, 0,  60, 0, 0, 1, 1, 1, 50));
        tbl.push_back(mk(1, 0,   2, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 0,  10, 0, 0, 0, 0, 0,  0));
        tbl.push_back(mk(0, 1,  25, 1, 0, 0, 0, 0, 20));

        @(negedge clk);
        foreach (tbl[i]) run_seg(i, tbl[i]);

        // Random key traffic checked cycle by cycle against the model
        begin
            bit lvl = 1'b0;
            for (int n = 0; n < 150; n++) begin
                int unsigned len;
                bit r;
                r   = ($urandom_range(0, 24) == 0);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 120)
                                                  : $urandom_range(1, 30);
                if (r) len = $urandom_range(1, 3);
                for (int i = 0; i < int'(len); i++) step(r, lvl);
                lvl = ~lvl;
            end
            for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
